// File: rtl/ca_pkg.sv
// Shared state encoding, rule constants and the per-cell rule lookup
// for the cellular-automaton line stepper.
package ca_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } ca_state_t;

   localparam logic [7:0] RULE_30  = 8'd30;
   localparam logic [7:0] RULE_90  = 8'd90;
   localparam logic [7:0] RULE_110 = 8'd110;

   localparam int CELLS_PER_WORD = 16;

   // The neighbourhood {L,C,R} selects one bit of the Wolfram rule number.
   function automatic logic rule_lookup(input logic [7:0] rule, input logic [2:0] nbhd);
      return rule[nbhd];
   endfunction

endpackage

// File: rtl/ca_word_eval.sv
// Combinational next-generation evaluation of one 16-cell word, given the
// edge neighbours from the adjacent words. Bit 15 is the leftmost cell.
module ca_word_eval
   import ca_pkg::*;
(
   input  logic                      i_left,
   input  logic [CELLS_PER_WORD-1:0] i_word,
   input  logic                      i_right,
   input  logic [7:0]                i_rule,
   output logic [CELLS_PER_WORD-1:0] o_next
);

   logic [CELLS_PER_WORD+1:0] w_ext;

   assign w_ext = {i_left, i_word, i_right};

   // Each cell looks at the 3-bit slice {left, self, right} of the extended word.
   always_comb begin
      o_next = '0;
      for (int b = 0; b < CELLS_PER_WORD; b++) begin
         o_next[b] = rule_lookup(i_rule, w_ext[b +: 3]);
      end
   end

endmodule

// File: rtl/ca_line_stepper.sv
// Computes one generation of a 1-D elementary cellular automaton per line,
// reading one RAM half and writing the other. CA_WRAP_EN selects a toroidal line.
module ca_line_stepper
   import ca_pkg::*;
#(
   parameter int WORDS  = 64,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              direction,
   input  logic [7:0]        rule,
   output logic              read,
   output logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] rdata,
   output logic              write,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done
);

`ifdef CA_WRAP_EN
   localparam logic WRAP = 1'b1;
`else
   localparam logic WRAP = 1'b0;
`endif

   localparam int CNT_W = $clog2(WORDS + 4);
   // r_cyc holds the index of the cycle that the next clock edge ends.
   localparam logic [CNT_W-1:0] C_LAST_CAP = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] C_FIRST_WR = CNT_W'(2);
   localparam logic [CNT_W-1:0] C_LAST_WR  = CNT_W'(WORDS + 1);
   localparam logic [CNT_W-1:0] C_END      = CNT_W'(WORDS + 2);

   ca_state_t         r_state;
   logic [CNT_W-1:0]  r_cyc;
   logic [7:0]        r_rule;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [DATA_W-1:0] r_cur;
   logic              r_left;
   logic              r_w0_b15;
   logic              r_read;
   logic [ADDR_W-1:0] r_raddr;
   logic              r_write;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_busy;
   logic              r_done;

   logic [ADDR_W-1:0] w_src_sel;
   logic [ADDR_W-1:0] w_dst_sel;
   logic              w_right;
   logic [DATA_W-1:0] w_next;

   assign w_src_sel = direction ? ADDR_W'(WORDS) : '0;
   assign w_dst_sel = direction ? '0 : ADDR_W'(WORDS);

   // The last word has no following read; its right neighbour is word 0's MSB.
   assign w_right = (r_cyc == C_LAST_WR) ? (WRAP ? r_w0_b15 : 1'b0) : rdata[DATA_W-1];

   ca_word_eval u_eval (
      .i_left  (r_left),
      .i_word  (r_cur),
      .i_right (w_right),
      .i_rule  (r_rule),
      .o_next  (w_next)
   );

   // Line sequencer: issues reads, shifts the word window and writes results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cyc    <= '0;
         r_rule   <= '0;
         r_src    <= '0;
         r_dst    <= '0;
         r_cur    <= '0;
         r_left   <= 1'b0;
         r_w0_b15 <= 1'b0;
         r_read   <= 1'b0;
         r_raddr  <= '0;
         r_write  <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done  <= 1'b0;
               r_write <= 1'b0;
               if (start) begin
                  r_rule  <= rule;
                  r_src   <= w_src_sel;
                  r_dst   <= w_dst_sel;
                  r_raddr <= w_src_sel + ADDR_W'(WORDS - 1);
                  r_read  <= 1'b1;
                  r_busy  <= 1'b1;
                  r_cyc   <= '0;
                  r_state <= S_PRIME;
               end else begin
                  r_read <= 1'b0;
                  r_busy <= 1'b0;
               end
            end
            S_PRIME, S_RUN, S_FLUSH: begin
               r_cyc <= r_cyc + CNT_W'(1);
               // Without wrap the primed word is masked so pixel 0 sees a zero left edge.
               if (r_cyc <= C_LAST_CAP) begin
                  r_cur  <= ((r_cyc == '0) && !WRAP) ? '0 : rdata;
                  r_left <= r_cur[0];
               end
               if (r_cyc == CNT_W'(1)) begin
                  r_w0_b15 <= rdata[DATA_W-1];
               end
               if (r_cyc < C_LAST_CAP) begin
                  r_read  <= 1'b1;
                  r_raddr <= r_src + ADDR_W'(r_cyc);
               end else begin
                  r_read  <= 1'b0;
               end
               if ((r_cyc >= C_FIRST_WR) && (r_cyc <= C_LAST_WR)) begin
                  r_write <= 1'b1;
                  r_waddr <= r_dst + ADDR_W'(r_cyc) - ADDR_W'(2);
                  r_wdata <= w_next;
               end else begin
                  r_write <= 1'b0;
               end
               if (r_cyc == '0) begin
                  r_state <= S_RUN;
               end else if (r_cyc == C_LAST_CAP) begin
                  r_state <= S_FLUSH;
               end else if (r_cyc == C_END) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_read  <= 1'b0;
               r_write <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign read  = r_read;
   assign raddr = r_raddr;
   assign write = r_write;
   assign waddr = r_waddr;
   assign wdata = r_wdata;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_ca_line_stepper.sv
// Self-checking bench for ca_line_stepper: directed vectors, corner sequences
// and random lines against a pixel-level reference model.
module tb_ca_line_stepper;
   import ca_pkg::*;

   localparam int WORDS  = 64;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int NPIX   = WORDS * 16;

`ifdef CA_WRAP_EN
   localparam bit TB_WRAP = 1'b1;
`else
   localparam bit TB_WRAP = 1'b0;
`endif

   typedef struct {
      logic [7:0]  rule_v;
      logic        dir;
      int          seed_w;
      logic [15:0] seed_v;
      int          chk_a;
      logic [15:0] exp_a;
      int          chk_b;
      logic [15:0] exp_b;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              direction = 1'b0;
   logic [7:0]        rule = 8'd0;
   logic              read;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata = '0;
   logic              write;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;

   logic [15:0]       mem   [0:2*WORDS-1];
   logic [15:0]       exp_w [0:WORDS-1];
   logic              pl_en = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   logic [15:0]       pl_data = '0;

   int n_cmp  = 0;
   int n_fail = 0;

   ca_line_stepper #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .direction(direction), .rule(rule),
      .read(read), .raddr(raddr), .rdata(rdata), .write(write), .waddr(waddr),
      .wdata(wdata), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Dual-port line RAM clocked on the inverted clock, plus a bench preload port.
   always @(negedge clk) begin
      if (read) rdata <= mem[raddr];
      if (write) mem[waddr] <= wdata;
      if (pl_en) mem[pl_addr] <= pl_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic poke(input int a, input logic [15:0] v);
      #1;
      pl_addr = ADDR_W'(a);
      pl_data = v;
      pl_en   = 1'b1;
      @(negedge clk);
      #1 pl_en = 1'b0;
   endtask

   // random_fill=1 fills the half with $urandom, else zeros plus one seed word.
   task automatic fill_src(input logic d, input bit random_fill, input int seed_w, input logic [15:0] seed_v);
      int base;
      base = d ? WORDS : 0;
      for (int i = 0; i < WORDS; i++) begin
         if (random_fill) poke(base + i, 16'($urandom));
         else poke(base + i, (i == seed_w) ? seed_v : 16'h0000);
      end
   endtask

   // Reference: unpack the line to pixels, apply the rule per pixel, repack.
   task automatic compute_expected(input logic d, input logic [7:0] rv);
      logic cells [0:NPIX-1];
      logic l, c, r;
      int base;
      base = d ? WORDS : 0;
      for (int p = 0; p < NPIX; p++) cells[p] = mem[base + p / 16][15 - p % 16];
      for (int p = 0; p < NPIX; p++) begin
         l = (p == 0) ? (TB_WRAP ? cells[NPIX-1] : 1'b0) : cells[p-1];
         r = (p == NPIX - 1) ? (TB_WRAP ? cells[0] : 1'b0) : cells[p+1];
         c = cells[p];
         exp_w[p / 16][15 - p % 16] = rv[{l, c, r}];
      end
   endtask

   // Run one line, checking the cycle-by-cycle protocol and the written half.
   task automatic run_line(input logic d, input logic [7:0] rv, input int restart_k, input int reset_k);
      int src, dst;
      src = d ? WORDS : 0;
      dst = d ? 0 : WORDS;
      compute_expected(d, rv);
      @(negedge clk);
      start = 1'b1; direction = d; rule = rv;
      @(posedge clk);
      #1;
      start = 1'b0; direction = ~d; rule = ~rv;
      for (int k = 0; k <= WORDS + 3; k++) begin
         @(negedge clk);
         if (k == restart_k) begin
            start = 1'b1; rule = 8'd0;
         end else begin
            start = 1'b0;
         end
         if (k == reset_k) begin
            rst_n = 1'b0;
            #1;
            chk("abort read", read, 0);
            chk("abort write", write, 0);
            chk("abort busy", busy, 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         chk($sformatf("read c%0d", k), read, (k <= WORDS) ? 1 : 0);
         if (k <= WORDS) chk($sformatf("raddr c%0d", k), raddr, (k == 0) ? src + WORDS - 1 : src + k - 1);
         chk($sformatf("write c%0d", k), write, (k >= 3 && k <= WORDS + 2) ? 1 : 0);
         if (k >= 3 && k <= WORDS + 2) begin
            chk($sformatf("waddr c%0d", k), waddr, dst + k - 3);
            chk($sformatf("wdata c%0d", k), wdata, exp_w[k-3]);
         end
         chk($sformatf("busy c%0d", k), busy, (k <= WORDS + 2) ? 1 : 0);
         chk($sformatf("done c%0d", k), done, (k == WORDS + 3) ? 1 : 0);
      end
      start = 1'b0;
      for (int i = 0; i < WORDS; i++) chk($sformatf("ram word %0d", dst + i), mem[dst + i], exp_w[i]);
   endtask

   initial begin
      vec_t vt [6];
      vt[0] = '{RULE_90,  1'b0, 31, 16'h0001, 31, 16'h0002, 32, 16'h8000};
      vt[1] = '{RULE_90,  1'b1,  0, 16'h8000,  0, 16'h4000, 63, TB_WRAP ? 16'h0001 : 16'h0000};
      vt[2] = '{8'd255,   1'b0,  5, 16'h1234,  0, 16'hFFFF, 63, 16'hFFFF};
      vt[3] = '{8'd0,     1'b1, 10, 16'hFFFF, 10, 16'h0000,  0, 16'h0000};
      vt[4] = '{RULE_30,  1'b0,  0, 16'h8000,  0, 16'hC000, 63, TB_WRAP ? 16'h0001 : 16'h0000};
      vt[5] = '{RULE_110, 1'b1, 63, 16'h0001, 63, 16'h0003,  0, 16'h0000};

      repeat (3) @(negedge clk);
      chk("reset read", read, 0);
      chk("reset write", write, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset raddr", raddr, 0);
      chk("reset waddr", waddr, 0);
      chk("reset wdata", wdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         fill_src(vt[v].dir, 1'b0, vt[v].seed_w, vt[v].seed_v);
         run_line(vt[v].dir, vt[v].rule_v, -1, -1);
         chk($sformatf("vec%0d word %0d", v, vt[v].chk_a),
             mem[(vt[v].dir ? 0 : WORDS) + vt[v].chk_a], vt[v].exp_a);
         chk($sformatf("vec%0d word %0d", v, vt[v].chk_b),
             mem[(vt[v].dir ? 0 : WORDS) + vt[v].chk_b], vt[v].exp_b);
      end

      // A second start mid-line must be ignored, with one done pulse only.
      fill_src(1'b0, 1'b1, 0, 16'h0000);
      run_line(1'b0, RULE_30, 10, -1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("no extra done %0d", k), done, 0);
         chk($sformatf("no extra busy %0d", k), busy, 0);
      end

      // Reset mid-line, then a complete line afterwards.
      run_line(1'b0, RULE_110, -1, 20);
      @(negedge clk);
      run_line(1'b0, RULE_90, -1, -1);

      // Back-to-back rule-110 lines ping-ponging between halves.
      fill_src(1'b0, 1'b1, 0, 16'h0000);
      for (int n = 0; n < 8; n++) run_line(n[0], RULE_110, -1, -1);

      // Random rules, directions and contents.
      for (int n = 0; n < 4; n++) begin
         logic d;
         d = 1'($urandom);
         fill_src(d, 1'b1, 0, 16'h0000);
         run_line(d, 8'($urandom), -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
